// File: rtl/noc_ni_tx.sv
// ---------------------------------------------------------------------------
// noc_ni_tx -- network-interface transmitter (PE -> mesh router local port)
//
// Takes {destination, payload} from the local processing element over a
// valid/ready interface and queues it in a small FIFO. It then launches one
// packet at a time towards the router using a 2-phase (transition-signalling)
// req/ack handshake. The router header {dst_x, dst_y, x_higher, y_higher} is
// computed when the packet is pushed, so the FIFO stores ready-to-send words.
//
// Ports
//   clk            clock
//   rst            asynchronous active-low reset
//   pkt_valid_i    local packet offered
//   pkt_ready_o    FIFO can accept (registered, equals !full)
//   pkt_dst_x_i    destination X coordinate
//   pkt_dst_y_i    destination Y coordinate
//   pkt_payload_i  payload
//   req_o          2-phase request, one toggle per packet
//   data_o         packet word, stable while a handshake is outstanding
//   ack_i          2-phase acknowledge from the router (asynchronous to clk)
//   busy_o         FIFO non-empty or handshake outstanding
//   sent_cnt_o     completed handshakes, wraps at 2^16
//   err_o          sticky ack-timeout flag
//
// Optional feature macro: NI_TX_ACK_TIMEOUT_EN
//   Defined   -> a 16-bit watchdog counts cycles spent waiting for ack and
//                sets err_o (sticky until reset) once it reaches TIMEOUT.
//   Undefined -> no watchdog is built and err_o is tied low.
// ---------------------------------------------------------------------------
module noc_ni_tx #(
  parameter int PAYLOAD     = 32,
  parameter int X_BITS      = 1,
  parameter int Y_BITS      = 1,
  parameter int MY_X        = 0,
  parameter int MY_Y        = 0,
  parameter int DEPTH       = 4,
  parameter int TIMEOUT     = 1024,
  parameter int packet_size = X_BITS + Y_BITS + 2 + PAYLOAD
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pkt_valid_i,
  output logic                   pkt_ready_o,
  input  logic [X_BITS-1:0]      pkt_dst_x_i,
  input  logic [Y_BITS-1:0]      pkt_dst_y_i,
  input  logic [PAYLOAD-1:0]     pkt_payload_i,
  output logic                   req_o,
  output logic [packet_size-1:0] data_o,
  input  logic                   ack_i,
  output logic                   busy_o,
  output logic [15:0]            sent_cnt_o,
  output logic                   err_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [X_BITS-1:0] MY_X_V   = X_BITS'(MY_X);
  localparam logic [Y_BITS-1:0] MY_Y_V   = Y_BITS'(MY_Y);
  localparam logic [CW-1:0]     FULL_CNT = CW'(DEPTH);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  // Elaboration-time parameter sanity checks.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $error("noc_ni_tx: DEPTH must be a power of two and at least 2");
  end
  if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_timeout_check
    $error("noc_ni_tx: TIMEOUT must fit the 16-bit watchdog (1..65535)");
  end

  state_t                 state;
  logic                   ack_s1, ack_s;
  logic [AW-1:0]          wr_ptr, rd_ptr;
  logic [CW-1:0]          count, count_next;
  logic                   push, pop;
  logic                   x_higher, y_higher;
  logic [packet_size-1:0] push_data;
  logic [packet_size-1:0] mem [DEPTH];

  // Header is built on the way in; unsigned compares against this node.
  assign x_higher  = (pkt_dst_x_i > MY_X_V);
  assign y_higher  = (pkt_dst_y_i > MY_Y_V);
  assign push_data = {pkt_dst_x_i, pkt_dst_y_i, x_higher, y_higher, pkt_payload_i};

  // pkt_ready_o is registered, so it is a safe push qualifier: it is low
  // whenever the FIFO is full, which makes push-while-full impossible.
  assign push = pkt_valid_i && pkt_ready_o;
  // Pop uses the registered count, so a packet pushed this edge is only
  // launched on the following edge.
  assign pop  = (state == S_IDLE) && (count != '0);

  always_comb begin
    // NOTE: default first so every path assigns count_next; otherwise a latch is inferred.
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  // Two-flop synchronizer: ack_i comes from the router's clock domain.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst) begin
      ack_s1 <= 1'b0;
      ack_s  <= 1'b0;
    end else begin
      ack_s1 <= ack_i;
      ack_s  <= ack_s1;
    end
  end

  // FIFO storage.
  // NOTE: the data array carries no reset; entries are never read before being written.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // FIFO pointers, occupancy and the registered ready flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      pkt_ready_o <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count       <= count_next;
      pkt_ready_o <= (count_next != FULL_CNT);
    end
  end

  // Launch FSM: IDLE pops and toggles req_o; WAIT holds req_o/data_o until
  // the synchronized ack phase catches up with req_o. An ack toggle seen in
  // IDLE is simply not looked at.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      req_o      <= 1'b0;
      data_o     <= '0;
      sent_cnt_o <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pop) begin
            data_o <= mem[rd_ptr];
            req_o  <= ~req_o;
            state  <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (ack_s == req_o) begin
            sent_cnt_o <= sent_cnt_o + 16'd1;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy_o = (count != '0) || (state == S_WAIT);

`ifdef NI_TX_ACK_TIMEOUT_EN
  logic [15:0] wd_cnt;
  logic        err_q;

  // Watchdog restarts on every launch and counts WAIT cycles; it saturates
  // rather than wrapping so a very long stall cannot re-arm it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_cnt <= '0;
      err_q  <= 1'b0;
    end else if (pop) begin
      wd_cnt <= '0;
    end else if (state == S_WAIT) begin
      if (wd_cnt != 16'hFFFF) wd_cnt <= wd_cnt + 16'd1;
      if ((32'(wd_cnt) + 32'd1) >= 32'(TIMEOUT)) err_q <= 1'b1;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_noc_ni_tx.sv
// ---------------------------------------------------------------------------
// tb_noc_ni_tx -- self-checking bench for noc_ni_tx.
// Instance dut sits at node (0,0); instance dut_b sits at node (1,1).
// The bench plays the router: it watches for req_o differing from ack_i,
// checks data_o against a queue-based model and answers by copying req_o
// onto ack_i. Inputs are driven and outputs sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_noc_ni_tx;

  localparam int PAYLOAD    = 32;
  localparam int XB         = 1;
  localparam int YB         = 1;
  localparam int DEPTH      = 4;
  localparam int TB_TIMEOUT = 8;
  localparam int PS         = XB + YB + 2 + PAYLOAD;
`ifdef NI_TX_ACK_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // dut: node (0,0)
  logic               pkt_valid_i = 1'b0;
  logic               pkt_ready_o;
  logic [XB-1:0]      pkt_dst_x_i = '0;
  logic [YB-1:0]      pkt_dst_y_i = '0;
  logic [PAYLOAD-1:0] pkt_payload_i = '0;
  logic               req_o;
  logic [PS-1:0]      data_o;
  logic               ack_i = 1'b0;
  logic               busy_o;
  logic [15:0]        sent_cnt_o;
  logic               err_o;

  // dut_b: node (1,1)
  logic               valid_b = 1'b0;
  logic               ready_b;
  logic [XB-1:0]      dst_x_b = '0;
  logic [YB-1:0]      dst_y_b = '0;
  logic [PAYLOAD-1:0] payload_b = '0;
  logic               req_b;
  logic [PS-1:0]      data_b;
  logic               ack_b = 1'b0;
  logic               busy_b;
  logic [15:0]        sent_b;
  logic               err_b;

  int errors = 0;
  int checks = 0;

  noc_ni_tx #(
    .PAYLOAD(PAYLOAD), .X_BITS(XB), .Y_BITS(YB), .MY_X(0), .MY_Y(0),
    .DEPTH(DEPTH), .TIMEOUT(TB_TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .pkt_valid_i(pkt_valid_i), .pkt_ready_o(pkt_ready_o),
    .pkt_dst_x_i(pkt_dst_x_i), .pkt_dst_y_i(pkt_dst_y_i), .pkt_payload_i(pkt_payload_i),
    .req_o(req_o), .data_o(data_o), .ack_i(ack_i),
    .busy_o(busy_o), .sent_cnt_o(sent_cnt_o), .err_o(err_o)
  );

  noc_ni_tx #(
    .PAYLOAD(PAYLOAD), .X_BITS(XB), .Y_BITS(YB), .MY_X(1), .MY_Y(1),
    .DEPTH(DEPTH), .TIMEOUT(TB_TIMEOUT)
  ) dut_b (
    .clk(clk), .rst(rst),
    .pkt_valid_i(valid_b), .pkt_ready_o(ready_b),
    .pkt_dst_x_i(dst_x_b), .pkt_dst_y_i(dst_y_b), .pkt_payload_i(payload_b),
    .req_o(req_b), .data_o(data_b), .ack_i(ack_b),
    .busy_o(busy_b), .sent_cnt_o(sent_b), .err_o(err_b)
  );

  // Reference: the packet word a node at (my_x,my_y) must emit.
  function automatic logic [PS-1:0] model_pkt(input int my_x, input int my_y,
                                              input logic [XB-1:0] dx, input logic [YB-1:0] dy,
                                              input logic [PAYLOAD-1:0] pl);
    logic xh, yh;
    xh = (int'(dx) > my_x);
    yh = (int'(dy) > my_y);
    return {dx, dy, xh, yh, pl};
  endfunction

  task automatic apply_reset;
    @(negedge clk);
    rst = 1'b0; pkt_valid_i = 1'b0; ack_i = 1'b0; valid_b = 1'b0; ack_b = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  // Offer one packet to dut; returns at the falling edge after the push.
  task automatic push_a(input logic [XB-1:0] dx, input logic [YB-1:0] dy,
                        input logic [PAYLOAD-1:0] pl, output bit ok);
    for (int w = 0; w < 100 && !pkt_ready_o; w++) @(negedge clk);
    ok = pkt_ready_o;
    if (!ok) return;
    pkt_valid_i = 1'b1; pkt_dst_x_i = dx; pkt_dst_y_i = dy; pkt_payload_i = pl;
    @(negedge clk);
    pkt_valid_i = 1'b0;
  endtask

  task automatic wait_outstanding(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (req_o !== ack_i) begin ok = 1'b1; return; end
      @(negedge clk);
    end
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (busy_o === 1'b0) begin ok = 1'b1; return; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst = 1'b0; ack_i = 1'b0; ack_b = 1'b0;
    #1;
    checks++; if (req_o !== 1'b0)    begin errors++; $display("FAIL reset_req: got %0b want 0", req_o); end
    checks++; if (data_o !== '0)     begin errors++; $display("FAIL reset_data: got %h want 0", data_o); end
    checks++; if (busy_o !== 1'b0)   begin errors++; $display("FAIL reset_busy: got %0b want 0", busy_o); end
    checks++; if (sent_cnt_o !== 16'd0) begin errors++; $display("FAIL reset_sent: got %0d want 0", sent_cnt_o); end
    checks++; if (err_o !== 1'b0)    begin errors++; $display("FAIL reset_err: got %0b want 0", err_o); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (pkt_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0b want 1", pkt_ready_o); end
  endtask

  task automatic test_single;
    bit ok;
    push_a(1'b1, 1'b0, 32'hFFFF_FFFF, ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_push: ready never rose"); end
    // One falling edge after the push edge: not launched yet.
    checks++; if (req_o !== 1'b0) begin errors++; $display("FAIL single_latency: req got %0b want 0", req_o); end
    @(negedge clk);
    checks++; if (req_o !== 1'b1) begin errors++; $display("FAIL single_req: got %0b want 1", req_o); end
    checks++; if (data_o !== 36'hA_FFFF_FFFF) begin errors++; $display("FAIL single_data: got %h want affffffff", data_o); end
    ack_i = 1'b1;
    wait_idle(20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_idle: busy stuck at 1"); end
    checks++; if (sent_cnt_o !== 16'd1) begin errors++; $display("FAIL single_sent: got %0d want 1", sent_cnt_o); end
  endtask

  task automatic test_back_to_back;
    logic [XB-1:0]      dx [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [YB-1:0]      dy [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [PS-1:0]      exp;
    int                 toggles = 0;
    bit                 ok;
    apply_reset;
    // Back-to-back pushes; the first one leaves the FIFO immediately, so the
    // fifth push is what fills the four entries.
    for (int i = 0; i < 5; i++) begin
      push_a(dx[i], dy[i], 32'(i), ok);
      if (!ok) begin errors++; checks++; $display("FAIL b2b_push%0d: ready never rose", i); end
    end
    checks++; if (pkt_ready_o !== 1'b0) begin errors++; $display("FAIL b2b_full: ready got %0b want 0", pkt_ready_o); end
    repeat (12) @(negedge clk);
    checks++; if (data_o !== 36'h5_0000_0000) begin errors++; $display("FAIL b2b_hold: data got %h want 500000000", data_o); end
    checks++; if (req_o !== 1'b1) begin errors++; $display("FAIL b2b_hold_req: got %0b want 1", req_o); end
    checks++; if (err_o !== TO_EN) begin errors++; $display("FAIL b2b_err: got %0b want %0b", err_o, TO_EN); end
    for (int i = 0; i < 5; i++) begin
      wait_outstanding(50, ok);
      if (!ok) begin errors++; checks++; $display("FAIL b2b_launch%0d: no request", i); break; end
      toggles++;
      exp = model_pkt(0, 0, dx[i], dy[i], 32'(i));
      checks++; if (data_o !== exp) begin errors++; $display("FAIL b2b_data%0d: got %h want %h", i, data_o, exp); end
      ack_i = req_o;
      @(negedge clk);
    end
    wait_idle(50, ok);
    checks++; if (toggles != 5) begin errors++; $display("FAIL b2b_toggles: got %0d want 5", toggles); end
    checks++; if (sent_cnt_o !== 16'd5) begin errors++; $display("FAIL b2b_sent: got %0d want 5", sent_cnt_o); end
    checks++; if (pkt_ready_o !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %0b want 1", pkt_ready_o); end
  endtask

  task automatic test_my_node;
    logic [XB-1:0]      dx;
    logic [YB-1:0]      dy;
    logic [PAYLOAD-1:0] pl;
    logic [PS-1:0]      exp;
    int                 w;
    for (int i = 0; i < 6; i++) begin
      if (i == 0) begin dx = 1'b0; dy = 1'b0; pl = 32'h1234_5678; end
      else begin dx = XB'($urandom); dy = YB'($urandom); pl = $urandom; end
      exp = model_pkt(1, 1, dx, dy, pl);
      for (w = 0; w < 100 && !ready_b; w++) @(negedge clk);
      valid_b = 1'b1; dst_x_b = dx; dst_y_b = dy; payload_b = pl;
      @(negedge clk);
      valid_b = 1'b0;
      for (w = 0; w < 20 && req_b === ack_b; w++) @(negedge clk);
      checks++;
      if (req_b === ack_b) begin errors++; $display("FAIL mynode_launch%0d: no request", i); end
      else if (data_b !== exp) begin errors++; $display("FAIL mynode_data%0d: got %h want %h", i, data_b, exp); end
      ack_b = req_b;
      for (w = 0; w < 20 && busy_b !== 1'b0; w++) @(negedge clk);
    end
    checks++; if (data_b[PAYLOAD+1:PAYLOAD] !== 2'b00 && dst_x_b == 1'b0 && dst_y_b == 1'b0)
      begin errors++; $display("FAIL mynode_higher: got %b want 00", data_b[PAYLOAD+1:PAYLOAD]); end
  endtask

  task automatic test_reset_mid_wait;
    bit ok;
    apply_reset;
    for (int i = 0; i < 2; i++) begin
      push_a(XB'($urandom), YB'($urandom), $urandom, ok);
      wait_outstanding(20, ok);
      ack_i = req_o;
      wait_idle(20, ok);
    end
    for (int i = 0; i < 3; i++) push_a(1'b1, 1'b1, $urandom, ok);
    @(negedge clk);
    checks++; if (req_o !== 1'b1 || busy_o !== 1'b1) begin errors++; $display("FAIL midwait_pre: req %0b busy %0b want 1 1", req_o, busy_o); end
    rst = 1'b0; ack_i = 1'b0;
    #1;
    checks++; if (req_o !== 1'b0) begin errors++; $display("FAIL midwait_req: got %0b want 0", req_o); end
    checks++; if (sent_cnt_o !== 16'd0) begin errors++; $display("FAIL midwait_sent: got %0d want 0", sent_cnt_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL midwait_busy: got %0b want 0", busy_o); end
    @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (pkt_ready_o !== 1'b1) begin errors++; $display("FAIL midwait_ready: got %0b want 1", pkt_ready_o); end
    checks++; if (req_o !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("FAIL midwait_empty: req %0b busy %0b want 0 0", req_o, busy_o); end
  endtask

  task automatic test_spurious_ack;
    bit ok;
    apply_reset;
    ack_i = 1'b1;
    repeat (4) @(negedge clk);
    ack_i = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (busy_o !== 1'b0 || sent_cnt_o !== 16'd0) begin errors++; $display("FAIL spurious_idle: busy %0b sent %0d want 0 0", busy_o, sent_cnt_o); end
    push_a(1'b0, 1'b1, 32'hCAFE_F00D, ok);
    wait_outstanding(20, ok);
    repeat (6) @(negedge clk);
    checks++; if (busy_o !== 1'b1 || sent_cnt_o !== 16'd0) begin errors++; $display("FAIL spurious_wait: busy %0b sent %0d want 1 0", busy_o, sent_cnt_o); end
    ack_i = req_o;
    wait_idle(20, ok);
    checks++; if (!ok || sent_cnt_o !== 16'd1) begin errors++; $display("FAIL spurious_done: sent got %0d want 1", sent_cnt_o); end
  endtask

  task automatic test_random;
    localparam int N = 40;
    logic [PS-1:0] q [$];
    apply_reset;
    fork
      begin : producer
        for (int i = 0; i < N; i++) begin
          logic [XB-1:0]      dx;
          logic [YB-1:0]      dy;
          logic [PAYLOAD-1:0] pl;
          repeat ($urandom_range(0, 3)) @(negedge clk);
          dx = XB'($urandom); dy = YB'($urandom); pl = $urandom;
          for (int w = 0; w < 200 && !pkt_ready_o; w++) @(negedge clk);
          if (!pkt_ready_o) begin errors++; checks++; $display("FAIL rand_ready%0d: stuck low", i); break; end
          q.push_back(model_pkt(0, 0, dx, dy, pl));
          pkt_valid_i = 1'b1; pkt_dst_x_i = dx; pkt_dst_y_i = dy; pkt_payload_i = pl;
          @(negedge clk);
          pkt_valid_i = 1'b0;
        end
      end
      begin : router
        for (int i = 0; i < N; i++) begin
          logic [PS-1:0] exp;
          bit ok;
          wait_outstanding(400, ok);
          if (!ok) begin errors++; checks++; $display("FAIL rand_launch%0d: no request", i); break; end
          checks++;
          if (q.size() == 0) begin errors++; $display("FAIL rand_extra%0d: launch with empty model", i); end
          else begin
            exp = q.pop_front();
            if (data_o !== exp) begin errors++; $display("FAIL rand_data%0d: got %h want %h", i, data_o, exp); end
          end
          repeat ($urandom_range(0, 5)) @(negedge clk);
          ack_i = req_o;
          @(negedge clk);
        end
      end
    join
    begin
      bit ok;
      wait_idle(50, ok);
    end
    checks++; if (sent_cnt_o !== 16'(N)) begin errors++; $display("FAIL rand_sent: got %0d want %0d", sent_cnt_o, N); end
    checks++; if (q.size() != 0) begin errors++; $display("FAIL rand_leftover: %0d packets never sent", q.size()); end
  endtask

`ifdef NI_TX_ACK_TIMEOUT_EN
  task automatic test_timeout;
    bit ok;
    apply_reset;
    push_a(1'b1, 1'b1, 32'h0BAD_0ACE, ok);
    wait_outstanding(20, ok);
    repeat (7) @(negedge clk);
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL timeout_early: got %0b want 0", err_o); end
    @(negedge clk);
    checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL timeout_set: got %0b want 1", err_o); end
    repeat (5) @(negedge clk);
    ack_i = req_o;
    wait_idle(20, ok);
    checks++; if (sent_cnt_o !== 16'd1) begin errors++; $display("FAIL timeout_late_ack: sent got %0d want 1", sent_cnt_o); end
    checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL timeout_sticky: got %0b want 1", err_o); end
  endtask
`endif

  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_my_node;
    test_reset_mid_wait;
    test_spurious_ack;
    test_random;
`ifdef NI_TX_ACK_TIMEOUT_EN
    test_timeout;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog so the run can never hang.
  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation exceeded time budget");
    $fatal(1, "time budget exceeded");
  end

endmodule
